// File: rtl/pll_div_lock_seq_pkg.sv
// pll_div_lock_seq_pkg: shared FSM state type, defaults and divider legality check
package pll_div_lock_seq_pkg;
  localparam int DIV_W_DEFAULT = 7;
  typedef enum logic [1:0] {IDLE, COUNT, LOCKED} pll_state_e;
  function automatic logic div_is_legal(input int unsigned n);
    return n inside {2, 3, 4, 5, 6, 8, 10, 12, 16, 20, 24, 32, 40, 48, 64};
  endfunction
endpackage

// File: rtl/pll_div_lock_seq_if.sv
// pll_div_lock_seq_if: enable/config inputs and divided-clock/status outputs of the lock sequencer
interface pll_div_lock_seq_if import pll_div_lock_seq_pkg::*; #(
  parameter int NUM_OUT = 4,
  parameter int DIV_W = DIV_W_DEFAULT
);
  logic                       pll_en;
  logic [NUM_OUT*DIV_W-1:0]   div_val;
  logic [NUM_OUT-1:0]         clk_out_en;
  logic [NUM_OUT-1:0]         clk_out;
  logic                       lock;
  logic                       cfg_err;
  modport master (output pll_en, div_val, clk_out_en, input clk_out, lock, cfg_err);
  modport slave (input pll_en, div_val, clk_out_en, output clk_out, lock, cfg_err);
endinterface

// File: rtl/pll_div_lock_seq_chan.sv
// pll_div_lock_seq_chan: one output divider with latched ratio, phase counter and glitch-free enable
module pll_div_lock_seq_chan import pll_div_lock_seq_pkg::*; #(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic             adv,
  input  logic [DIV_W-1:0] div_in,
  input  logic             en_in,
  output logic             illegal,
  output logic             clk_out
);
  logic [DIV_W-1:0] n_q, n_d, cnt_q, cnt_d;
  logic             en_q, en_d, wrap;
  // enable only reloads at a counter wrap, which is always a rising boundary
  always_comb begin
    illegal = !div_is_legal(32'(div_in));
    wrap = adv && cnt_q == n_q - DIV_W'(1);
    n_d = clr ? '0 : load ? (illegal ? DIV_W'(2) : div_in) : n_q;
    cnt_d = (clr || load || wrap) ? '0 : adv ? cnt_q + DIV_W'(1) : cnt_q;
    en_d = clr ? 1'b0 : (load || wrap) ? en_in : en_q;
  end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      {n_q, cnt_q, en_q, clk_out} <= '0;
    end else begin
      n_q <= n_d;
      cnt_q <= cnt_d;
      en_q <= en_d;
      clk_out <= en_d && cnt_d < (n_d >> 1);
    end
endmodule

// File: rtl/pll_div_lock_seq.sv
// pll_div_lock_seq: lock-time sequencer driving phase-aligned programmable output dividers
module pll_div_lock_seq import pll_div_lock_seq_pkg::*; #(
  parameter int    NUM_OUT = 4,
  parameter int    DIV_W = DIV_W_DEFAULT,
  parameter int    LOCK_CYCLES = 1024,
  parameter string DIVIDE_CLK_IN_BY_2 = "FALSE"
) (
  input logic               clk_in,
  input logic               rst_n,
  pll_div_lock_seq_if.slave bus
);
  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam bit PREDIV = DIVIDE_CLK_IN_BY_2 == "TRUE";
  pll_state_e         state;
  logic [CNT_W-1:0]   lock_cnt;
  logic               tog, lock_q, cfg_q, lock_edge, adv;
  logic [NUM_OUT-1:0] illegal;
  assign lock_edge = bus.pll_en && state == COUNT && lock_cnt == CNT_W'(LOCK_CYCLES - 1);
  assign adv = bus.pll_en && state == LOCKED && (!PREDIV || tog);
  assign bus.lock = lock_q;
  assign bus.cfg_err = cfg_q;
  // tog is set on the lock edge so the first pre-divided advance is the following edge
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      lock_cnt <= '0;
      lock_q <= 1'b0;
      tog <= 1'b0;
      cfg_q <= 1'b0;
    end else if (!bus.pll_en) begin
      state <= IDLE;
      lock_cnt <= '0;
      lock_q <= 1'b0;
      tog <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= COUNT;
          lock_cnt <= CNT_W'(1);
        end
        COUNT: begin
          lock_cnt <= lock_cnt + CNT_W'(1);
          if (lock_edge) begin
            state <= LOCKED;
            lock_q <= 1'b1;
            tog <= 1'b1;
            cfg_q <= cfg_q || |illegal;
          end
        end
        default: tog <= ~tog;
      endcase
    end
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chan
    pll_div_lock_seq_chan #(.DIV_W(DIV_W)) u_chan (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .clr     (!bus.pll_en),
      .load    (lock_edge),
      .adv     (adv),
      .div_in  (bus.div_val[i*DIV_W +: DIV_W]),
      .en_in   (bus.clk_out_en[i]),
      .illegal (illegal[i]),
      .clk_out (bus.clk_out[i])
    );
  end
endmodule
